// File: rtl/adder_operand_sequencer.sv
// Pairs an incoming nibble stream into {B, A} operand bytes for the ripple adder
// and queues completed pairs in a small first-word fall-through FIFO.
module adder_operand_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NIB_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    input  logic [NIB_W-1:0]       in_nibble,
    output logic                   in_ready,
    output logic                   op_valid,
    output logic [2*NIB_W-1:0]     op_data,
    input  logic                   op_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   have_a
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic {StWaitA, StHaveA} state_e;

    state_e             state_q, state_d;
    logic [NIB_W-1:0]   a_q, a_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    // Low only in reset; keeps in_ready at 0 until the first edge out of reset.
    logic               run_q, run_d;
    logic               accept, push, pop;

    logic [2*NIB_W-1:0] mem [DEPTH];

    assign in_ready = run_q & ((state_q == StWaitA) | (level_q != LW'(DEPTH)));
    assign op_valid = (level_q != '0);
    assign op_data  = op_valid ? mem[rd_ptr_q] : '0;
    assign level    = level_q;
    assign have_a   = (state_q == StHaveA);

    assign accept = in_valid & in_ready;
    assign push   = accept & (state_q == StHaveA);
    assign pop    = op_valid & op_ready;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        run_d    = 1'b1;

        if (accept) begin
            if (state_q == StWaitA) begin
                a_d     = in_nibble;
                state_d = StHaveA;
            end else begin
                state_d  = StWaitA;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (clear) begin
            state_d  = StWaitA;
            a_d      = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StWaitA;
            a_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            run_q    <= run_d;
        end
    end

    // Storage is not reset: op_data is gated to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && !clear && push) begin
            mem[wr_ptr_q] <= {in_nibble, a_q};
        end
    end

endmodule
